// File: rtl/ro_meas_ctrl.sv
// rtl/ro_meas_ctrl.sv - ring-oscillator measurement sequencer (settle, windowed edge count, publish)
module ro_meas_ctrl #(
    parameter int WIN_W       = 16,
    parameter int CNT_W       = 16,
    parameter int SETTLE_CYC  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             ro_clk,
    input  logic             ro_rst,
    input  logic             ro_start,
    input  logic             ro_abort,
    input  logic [WIN_W-1:0] ro_win_len,
    input  logic             ro_q_i,
    output logic             ro_en,
    output logic             ro_busy,
    output logic             ro_done,
    output logic [CNT_W-1:0] ro_count,
    output logic             ro_ovf
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COUNT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [SET_W-1:0]       set_q, set_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   en_q, busy_q, done_q;
    logic                   rise;
    logic                   accept;

    assign rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign accept = (state_q == S_IDLE) && ro_start && !ro_abort;

    always_ff @(posedge ro_clk or posedge ro_rst) begin
        if (ro_rst) begin
            state_q <= S_IDLE;
            sync_q  <= '0;
            hist_q  <= 1'b0;
            win_q   <= '0;
            set_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ro_q_i};
            hist_q  <= sync_q[SYNC_STAGES-1];
            win_q   <= win_d;
            set_q   <= set_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            // Outputs are registered from the next state so they line up with it
            en_q    <= (state_d == S_SETTLE) || (state_d == S_COUNT);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (ro_win_len == '0) ? S_DONE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (ro_abort)          state_d = S_IDLE;
                else if (set_q == '0)  state_d = S_COUNT;
            end
            S_COUNT: begin
                if (ro_abort)                    state_d = S_IDLE;
                else if (win_q == WIN_W'(1))     state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        win_d   = win_q;
        set_d   = set_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    win_d = ro_win_len;
                    set_d = SET_LOAD;
                    cnt_d = '0;
                    sat_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (set_q != '0) set_d = set_q - 1'b1;
            end
            S_COUNT: begin
                win_d = win_q - 1'b1;
                if (rise) begin
                    if (&cnt_q) sat_d = 1'b1;
                    else        cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        // Publish includes the final window cycle's edge
        if (state_d == S_DONE) begin
            count_d = cnt_d;
            ovf_d   = sat_d;
        end
    end

    assign ro_en    = en_q;
    assign ro_busy  = busy_q;
    assign ro_done  = done_q;
    assign ro_count = count_q;
    assign ro_ovf   = ovf_q;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// tb/tb_ro_meas_ctrl.sv - randomized self-checking bench for ro_meas_ctrl
module tb_ro_meas_ctrl;

    localparam int S    = 4;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, q;
    logic [15:0] win;
    logic        en, busy, done, ovf;
    logic [15:0] count;

    logic        start2, abort2, q2;
    logic [15:0] win2;
    logic        en2, busy2, done2, ovf2;
    logic [3:0]  count2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mode    = 0;
    int per     = 6;
    int hi      = 3;
    bit sat_on  = 0;
    bit qlog [65536];
    int last_cnt = 0;
    int last_ovf = 0;

    ro_meas_ctrl u_dut (
        .ro_clk(clk), .ro_rst(rst), .ro_start(start), .ro_abort(abort),
        .ro_win_len(win), .ro_q_i(q), .ro_en(en), .ro_busy(busy),
        .ro_done(done), .ro_count(count), .ro_ovf(ovf)
    );

    ro_meas_ctrl #(.CNT_W(4)) u_sat (
        .ro_clk(clk), .ro_rst(rst), .ro_start(start2), .ro_abort(abort2),
        .ro_win_len(win2), .ro_q_i(q2), .ro_en(en2), .ro_busy(busy2),
        .ro_done(done2), .ro_count(count2), .ro_ovf(ovf2)
    );

    always #5 clk = ~clk;

    // Waveform source; qlog[k] is the value sampled at edge k
    initial begin
        q  = 1'b0;
        q2 = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            qlog[cyc % 65536] = q;
            #2;
            case (mode)
                1:       q = ((cyc % per) < hi);
                2:       q = 1'($urandom_range(0, 1));
                default: q = 1'b0;
            endcase
            q2 = sat_on ? 1'(cyc % 2) : 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Rising edges seen by the counter: a 0->1 in the sampled input lands in cycle j+SYNC
    function automatic int model_count(input int e0, input int w);
        int n = 0;
        for (int c = e0 + 1 + S; c <= e0 + S + w; c++) begin
            if (qlog[(c - SYNC) % 65536] && !qlog[(c - SYNC - 1) % 65536]) n++;
        end
        return n;
    endfunction

    task automatic measure(input int w, input int abort_at, input int poke_at);
        int e0, lat, en_n, busy_n, done_n, raw, exp_lat;
        logic [15:0] cnt_at_done;
        logic ovf_at_done, en_after;
        @(negedge clk);
        start = 1'b1;
        win   = 16'(w);
        @(posedge clk);
        #1;
        e0    = cyc;
        start = 1'b0;
        win   = 16'($urandom);
        lat = 0; en_n = 0; busy_n = 0; done_n = 0;
        cnt_at_done = '0; ovf_at_done = 1'b0; en_after = 1'b1;
        for (int k = 1; k <= S + w + 5; k++) begin
            @(negedge clk);
            if (en)   en_n++;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat == 0) lat = k;
                cnt_at_done = count;
                ovf_at_done = ovf;
            end
            if (k == abort_at + 1) en_after = en;
            abort = (k == abort_at);
            start = (k == poke_at);
        end
        abort = 1'b0;
        start = 1'b0;
        if (abort_at > 0) begin
            check("abort_no_done", done_n, 0);
            check("abort_en_drop", en_after, 0);
            check("abort_busy_cycles", busy_n, abort_at);
            check("abort_count_held", count, last_cnt);
            check("abort_ovf_held", ovf, last_ovf);
        end else begin
            raw     = model_count(e0, w);
            exp_lat = (w == 0) ? 1 : S + w + 1;
            last_cnt = (raw > 65535) ? 65535 : raw;
            last_ovf = (raw > 65535) ? 1 : 0;
            check("done_pulses", done_n, 1);
            check("done_latency", lat, exp_lat);
            check("count", cnt_at_done, last_cnt);
            check("ovf", ovf_at_done, last_ovf);
            check("en_cycles", en_n, (w == 0) ? 0 : S + w);
            check("busy_cycles", busy_n, exp_lat);
            check("count_held", count, last_cnt);
        end
    endtask

    task automatic sat_run(input int exp_cnt, input int exp_ovf);
        bit seen;
        logic [3:0] c;
        logic o;
        seen = 0; c = '0; o = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        win2   = 16'd40;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done2 && !seen) begin
                seen = 1;
                c = count2;
                o = ovf2;
            end
        end
        check("sat_done_seen", seen, 1);
        check("sat_count", c, exp_cnt);
        check("sat_ovf", o, exp_ovf);
    endtask

    initial begin
        bit act;
        int w, ab;
        rst = 1'b1; start = 1'b0; abort = 1'b0; win = '0;
        start2 = 1'b0; abort2 = 1'b0; win2 = '0;
        repeat (3) @(negedge clk);
        check("rst_en", en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        mode = 1; per = 6; hi = 3;
        measure(60, -1, -1);
        check("basic_count10", count, 10);
        measure(100, S + 30, -1);
        measure(0, -1, -1);
        measure(60, -1, 10);

        // start and abort together in IDLE: nothing happens
        @(negedge clk);
        start = 1'b1; abort = 1'b1; win = 16'd20;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        act = 0;
        repeat (6) begin
            @(negedge clk);
            act = act | busy | en | done;
        end
        check("idle_collide", act, 0);

        sat_on = 1;
        repeat (4) @(negedge clk);
        sat_run(15, 1);
        sat_on = 0;
        repeat (4) @(negedge clk);
        sat_run(0, 0);

        // reset in the middle of a count window
        @(negedge clk);
        start = 1'b1; win = 16'd60;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_en", en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        last_cnt = 0; last_ovf = 0;
        repeat (3) @(negedge clk);
        measure(60, -1, -1);
        check("post_rst_count10", count, 10);

        for (int i = 0; i < 25; i++) begin
            mode = $urandom_range(1, 2);
            per  = $urandom_range(2, 9);
            hi   = $urandom_range(1, per - 1);
            w    = $urandom_range(0, 150);
            ab   = (w > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, S + w) : -1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            measure(w, ab, (ab < 0 && w > 2) ? 2 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
